test_sig_gen: RTL and testbench

Parametrised multi-channel test-signal generator. It replaces the single fixed `test1` stimulus line with NUM_CH independently configurable channels. Each channel runs in one of four modes: level, toggle, pulse or pseudo-random. A bench or on-chip test controller configures each channel over a valid/ready port, then starts and stops channels individually; the outputs feed the test-signal interface of the unit under test.

---
 rtl/test_sig_gen_pkg.sv | 25 ++
 rtl/test_sig_gen_if.sv | 24 ++
 rtl/test_sig_gen_chan.sv | 91 +++++++++
 rtl/test_sig_gen.sv | 55 +++++
 tb/tb_test_sig_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/test_sig_gen_pkg.sv
// Shared types and constants for the multi-channel test-signal generator.
package test_sig_pkg;

  typedef enum logic [1:0] {
    LEVEL  = 2'd0,
    TOGGLE = 2'd1,
    PULSE  = 2'd2,
    LFSR   = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int               LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  // Fibonacci step for x^16+x^14+x^13+x^11+1; the new bit enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/test_sig_gen_if.sv
// Configuration port of the test-signal generator: one valid/ready transfer per cycle.
interface test_sig_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  test_sig_pkg::mode_e  cfg_mode;
  logic [CNT_W-1:0]     cfg_period;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_period,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_period,
    output cfg_ready
  );

endinterface

// File: rtl/test_sig_gen_chan.sv
// One generator channel: config registers, IDLE/RUN FSM, period counter and LFSR.
module test_sig_chan
  import test_sig_pkg::*;
#(
  parameter int                CNT_W = 8,
  parameter logic [LFSR_W-1:0] SEED  = LFSR_SEED
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cfg_we,
  input  mode_e            cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             test_out,
  output logic             tick
);

  mode_e             mode_q;
  logic [CNT_W-1:0]  period_q;
  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [CNT_W-1:0]  last;
  logic              tc;
  mode_e             entry_mode;

  // A config written in the same cycle as start must already govern the run.
  always_comb begin
    last       = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    tc         = (cnt == last);
    lfsr_nxt   = lfsr_next(lfsr);
    entry_mode = cfg_we ? cfg_mode : mode_q;
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      mode_q   <= TOGGLE;
      period_q <= CNT_W'(1);
      state    <= IDLE;
      cnt      <= '0;
      lfsr     <= SEED;
      test_out <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (cfg_we) begin
        mode_q   <= cfg_mode;
        period_q <= cfg_period;
      end
      unique case (state)
        IDLE: begin
          cnt      <= '0;
          tick     <= 1'b0;
          test_out <= 1'b0;
          if (start && !stop) begin
            state    <= RUN;
            test_out <= (entry_mode == LEVEL);
          end
        end
        RUN: begin
          if (stop) begin
            state    <= IDLE;
            cnt      <= '0;
            tick     <= 1'b0;
            test_out <= 1'b0;
          end else begin
            tick <= tc;
            cnt  <= tc ? '0 : cnt + CNT_W'(1);
            // The LFSR only advances on terminal count and keeps its state across runs.
            unique case (mode_q)
              LEVEL:  test_out <= 1'b1;
              TOGGLE: if (tc) test_out <= ~test_out;
              PULSE:  test_out <= tc;
              LFSR: begin
                if (tc) begin
                  lfsr     <= lfsr_nxt;
                  test_out <= lfsr_nxt[0];
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/test_sig_gen.sv
// Multi-channel test-signal generator: shared cfg port decode plus NUM_CH channels.
module test_sig_gen
  import test_sig_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  test_sig_gen_if.slave     cfg,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] test_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_ready_c;
  logic [NUM_CH-1:0] cfg_we;

  // Out-of-range channel numbers match no channel, so they are never ready.
  always_comb begin
    cfg_ready_c = 1'b0;
    cfg_we      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i) && !busy[i]) begin
        cfg_ready_c = 1'b1;
        cfg_we[i]   = cfg.cfg_valid;
      end
    end
  end

  assign cfg.cfg_ready = cfg_ready_c;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    test_sig_chan #(
      .CNT_W (CNT_W),
      .SEED  (LFSR_SEED ^ LFSR_W'(g))
    ) u_chan (
      .clk        (clk),
      .rstb       (rstb),
      .cfg_we     (cfg_we[g]),
      .cfg_mode   (cfg.cfg_mode),
      .cfg_period (cfg.cfg_period),
      .start      (start[g]),
      .stop       (stop[g]),
      .busy       (busy[g]),
      .test_out   (test_out[g]),
      .tick       (tick[g])
    );
  end

endmodule

// File: tb/tb_test_sig_gen.sv
// Self-checking bench: directed scenarios with literal pins plus randomized traffic
// checked every cycle against a cycle-count based behavioural model.
module tb_test_sig_gen;
  import test_sig_pkg::*;

  localparam int NCH = 5;
  localparam int CW  = 8;

  logic           clk;
  logic           rstb;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] test_out;
  logic [NCH-1:0] tick;

  int checks;
  int errors;

  test_sig_gen_if #(.NUM_CH(NCH), .CNT_W(CW)) cfg_if ();

  test_sig_gen #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .cfg      (cfg_if),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .test_out (test_out),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: configuration, run flag, cycles since start, LFSR.
  int          m_mode[NCH];
  int          m_per[NCH];
  bit          m_run[NCH];
  int          m_n[NCH];
  int          m_shifts[NCH];
  logic [15:0] m_lfsr[NCH];
  bit          e_out[NCH];
  bit          e_tick[NCH];

  logic           s_rstb, s_valid;
  int             s_ch, s_mode, s_per;
  logic [NCH-1:0] s_start, s_stop;
  bit             exp_ready;

  function automatic logic [15:0] modelStep(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic checkOutput(input string name, input int ch, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s ch%0d: got %0d, want %0d at %0t", name, ch, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    s_rstb  = rstb;
    s_valid = cfg_if.cfg_valid;
    s_ch    = int'(cfg_if.cfg_ch);
    s_mode  = int'(cfg_if.cfg_mode);
    s_per   = int'(cfg_if.cfg_period);
    s_start = start;
    s_stop  = stop;
    for (int c = 0; c < NCH; c++) begin
      if (!s_rstb) begin
        m_mode[c] = int'(TOGGLE); m_per[c] = 1; m_run[c] = 0; m_n[c] = 0;
        m_shifts[c] = 0; m_lfsr[c] = 16'hACE1 ^ 16'(c);
        e_out[c] = 0; e_tick[c] = 0;
      end else begin
        if (s_valid && s_ch == c && !m_run[c]) begin
          m_mode[c] = s_mode;
          m_per[c]  = s_per;
        end
        if (m_run[c]) begin
          if (s_stop[c]) begin
            m_run[c] = 0; e_out[c] = 0; e_tick[c] = 0;
          end else begin
            int p;
            p = (m_per[c] == 0) ? 1 : m_per[c];
            m_n[c]++;
            e_tick[c] = (m_n[c] % p) == 0;
            case (m_mode[c])
              0: e_out[c] = 1;
              1: e_out[c] = ((m_n[c] / p) % 2) == 1;
              2: e_out[c] = e_tick[c];
              default: begin
                if (e_tick[c]) begin
                  m_lfsr[c] = modelStep(m_lfsr[c]);
                  m_shifts[c]++;
                end
                e_out[c] = (m_shifts[c] > 0) ? m_lfsr[c][0] : 1'b0;
              end
            endcase
          end
        end else if (s_start[c] && !s_stop[c]) begin
          m_run[c] = 1; m_n[c] = 0; m_shifts[c] = 0;
          e_tick[c] = 0; e_out[c] = (m_mode[c] == 0);
        end else begin
          e_out[c] = 0; e_tick[c] = 0;
        end
      end
    end
    #2;
    for (int c = 0; c < NCH; c++) begin
      checkOutput("busy", c, int'(busy[c]), int'(m_run[c]));
      checkOutput("test_out", c, int'(test_out[c]), int'(e_out[c]));
      checkOutput("tick", c, int'(tick[c]), int'(e_tick[c]));
    end
    exp_ready = (int'(cfg_if.cfg_ch) < NCH) && !m_run[int'(cfg_if.cfg_ch) % NCH];
    checkOutput("cfg_ready", -1, int'(cfg_if.cfg_ready), int'(exp_ready));
  end

  // Drive one cycle of inputs at the falling edge, return just after the next rising edge.
  task automatic applyStimulus(input logic v, input int ch, input int mode, input int per,
                               input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    logic [1:0] m2;
    @(negedge clk);
    m2 = mode[1:0];
    cfg_if.cfg_valid  = v;
    cfg_if.cfg_ch     = 3'(ch);
    cfg_if.cfg_mode   = mode_e'(m2);
    cfg_if.cfg_period = 8'(per);
    start = st;
    stop  = sp;
    @(posedge clk);
    #3;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstb = 1'b0;
    start = '0;
    stop  = '0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0;
    cfg_if.cfg_mode = TOGGLE; cfg_if.cfg_period = '0;

    // Reset with every start asserted.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, '1, '0);
      checkOutput("rst_busy", -1, int'(busy), 0);
      checkOutput("rst_out", -1, int'(test_out), 0);
      checkOutput("rst_tick", -1, int'(tick), 0);
    end
    rstb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, '0, '0);
      checkOutput("idle_out", -1, int'(test_out), 0);
    end

    // TOGGLE, P=4 on channel 1.
    applyStimulus(1, 1, int'(TOGGLE), 4, '0, '0);
    applyStimulus(0, 0, 0, 0, 5'b00010, '0);
    checkOutput("tog_busy", 1, int'(busy[1]), 1);
    for (int n = 1; n <= 12; n++) begin
      applyStimulus(0, 0, 0, 0, '0, '0);
      if (n == 3) checkOutput("tog_out_n3", 1, int'(test_out[1]), 0);
      if (n == 4) checkOutput("tog_out_n4", 1, int'(test_out[1]), 1);
      if (n == 8) checkOutput("tog_out_n8", 1, int'(test_out[1]), 0);
      if (n == 4 || n == 8 || n == 12) checkOutput("tog_tick", 1, int'(tick[1]), 1);
      if (n == 5) checkOutput("tog_tick_n5", 1, int'(tick[1]), 0);
      checkOutput("tog_other_tick", -1, int'(tick & 5'b11101), 0);
    end
    applyStimulus(0, 0, 0, 0, '0, 5'b00010);

    // PULSE, P=3 on channel 2, then stop.
    applyStimulus(1, 2, int'(PULSE), 3, '0, '0);
    applyStimulus(0, 0, 0, 0, 5'b00100, '0);
    for (int n = 1; n <= 9; n++) begin
      applyStimulus(0, 0, 0, 0, '0, '0);
      checkOutput("pulse_out", 2, int'(test_out[2]), (n % 3 == 0) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, '0, 5'b00100);
    checkOutput("pulse_stop_busy", 2, int'(busy[2]), 0);
    checkOutput("pulse_stop_out", 2, int'(test_out[2]), 0);

    // LFSR, P=1 on channel 0; first outputs from seed ACE1 are 1,1,1,0.
    applyStimulus(1, 0, int'(LFSR), 1, '0, '0);
    applyStimulus(0, 0, 0, 0, 5'b00001, '0);
    for (int n = 1; n <= 100; n++) begin
      applyStimulus(0, 0, 0, 0, '0, '0);
      if (n <= 4) checkOutput("lfsr_pin", 0, int'(test_out[0]), (n == 4) ? 0 : 1);
    end
    applyStimulus(0, 0, 0, 0, '0, 5'b00001);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, 0, 5'b00001, '0);
    for (int n = 0; n < 30; n++) applyStimulus(0, 0, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, 0, '0, 5'b00001);

    // Channel 3: config attempt while running is refused; P=0 acts as P=1.
    applyStimulus(1, 3, int'(LEVEL), 2, '0, '0);
    applyStimulus(0, 0, 0, 0, 5'b01000, '0);
    checkOutput("level_entry", 3, int'(test_out[3]), 1);
    applyStimulus(1, 3, int'(PULSE), 0, '0, '0);
    checkOutput("cfg_ready_run", 3, int'(cfg_if.cfg_ready), 0);
    for (int n = 0; n < 6; n++) begin
      applyStimulus(0, 0, 0, 0, '0, '0);
      checkOutput("level_hold", 3, int'(test_out[3]), 1);
    end
    applyStimulus(0, 0, 0, 0, '0, 5'b01000);
    applyStimulus(1, 3, int'(TOGGLE), 0, '0, '0);
    applyStimulus(0, 0, 0, 0, 5'b01000, '0);
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(0, 0, 0, 0, '0, '0);
      checkOutput("p0_tick", 3, int'(tick[3]), 1);
      checkOutput("p0_out", 3, int'(test_out[3]), n % 2);
    end
    applyStimulus(0, 0, 0, 0, '0, 5'b01000);

    // Start and stop together from IDLE; out-of-range cfg channel.
    applyStimulus(1, NCH, int'(LEVEL), 2, 5'b00001, 5'b00001);
    checkOutput("startstop_busy", 0, int'(busy[0]), 0);
    checkOutput("cfg_ready_oor", NCH, int'(cfg_if.cfg_ready), 0);

    // Randomized traffic, occasional mid-run reset.
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] st, sp;
      for (int c = 0; c < NCH; c++) begin
        st[c] = ($urandom_range(0, 5) == 0);
        sp[c] = ($urandom_range(0, 11) == 0);
      end
      rstb = ($urandom_range(0, 99) != 0);
      applyStimulus(logic'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), st, sp);
    end
    rstb = 1'b1;
    applyStimulus(0, 0, 0, 0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
